layer_seq_ctrl: RTL and testbench
=================================

Name: layer_seq_ctrl

Overview:
- Sequencer between two fully connected neuron layers.
- Captures the NN parallel outputs of layer N once every neuron has flagged valid.
- Streams the captured values serially, one per cycle, into the shared x_in / x_valid input of layer N+1, with a downstream stall.
- Reports overflow when a new result set arrives before the previous one has drained.

Parameters:
- NN, 30, number of neurons in the upstream layer (values per frame); legal range 2..256.
- dataWidth, 16, width of each neuron output, signed two's complement.
- IDX_W, 8, width of index outputs; must satisfy 2**IDX_W >= NN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- up_valid  in  NN  per-neuron outvalid from the upstream layer.
- up_data  in  NN*dataWidth  upstream outputs; neuron k occupies bits [k*dataWidth +: dataWidth].
- dn_stall  in  1  downstream hold request; when high, no value is issued.
- x_valid  out  1  registered; one value presented to the next layer this cycle.
- x_out  out  dataWidth  registered serial data to the next layer.
- x_idx  out  IDX_W  index of the value on x_out.
- frame_done  out  1  single-cycle pulse in the cycle after the last value is issued.
- busy  out  1  high while in SHIFT or DONE.
- overflow  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst=0 at a clock edge) sets all outputs, the counter, the capture flags and the buffer to 0, and the FSM to IDLE. Reset takes effect mid-frame, and the partial frame is discarded.
- Capture:
  - A per-neuron flag is set when up_valid[k] is high. While the flag is set, up_data[k] is latched into buffer[k].
  - up_valid bits may arrive in different cycles.
  - A capture completes in the cycle in which all NN flags are set, counting bits that arrive in that same cycle.
- FSM states:
  - IDLE: when a capture completes, clear the flags and the counter, go to SHIFT.
  - SHIFT: in each cycle with dn_stall=0, register x_valid=1, x_out=buffer[cnt], x_idx=cnt, then cnt++. In a cycle with dn_stall=1, register x_valid=0 and hold cnt. After issuing index NN-1, go to DONE.
  - DONE: frame_done=1 for one cycle, then go to IDLE. If a complete capture is already pending, go directly to SHIFT.
- Latency:
  - The first x_valid is registered 1 cycle after capture completes.
  - An unstalled frame occupies exactly NN consecutive x_valid cycles.
- Buffering:
  - Single shadow set. Capture flags keep accumulating during SHIFT and DONE, into a separate pending buffer.
  - A second complete capture while one is already pending sets overflow. The pending buffer keeps the older data and the newer frame is dropped.
- A capture and the issue of the last value in the same cycle is legal: the new frame becomes pending, no overflow.
- busy=1 in SHIFT and DONE.

Optional Feature:
- Macro: LAYER_SEQ_ARGMAX_EN.
- When defined:
  - Adds outputs max_idx (IDX_W) and max_valid (1).
  - A running signed compare over the issued values keeps the largest; on ties the lowest index wins.
  - max_valid pulses together with frame_done, with max_idx registered. max_idx holds its value until the next frame_done.
  - Used on the final classifier layer.
- When undefined: ports and comparator are absent; all other behaviour is identical.

Decomposition:
- Shared package layer_seq_pkg holds:
  - state encoding typedef: IDLE=0, SHIFT=1, DONE=2;
  - function clog2_nn;
  - localparam FRAME_LAST = NN-1.
- One natural sub-module, layer_capture_buf, owns the valid-flag accumulation and the active/pending buffers. The FSM, counter and argmax logic stay in the top.

Test Plan:
- Set NN=4, dataWidth=16, with all up_valid pulsing together, data {0x0010,0x0020,0x0030,0x0040}. Expect x_valid for 4 cycles starting 1 cycle later, x_out 0x0010..0x0040, x_idx 0..3, then frame_done 1 cycle after idx 3.
- Pulse up_valid bits in cycles 0, 3, 5 and 9, one neuron each. Expect no x_valid before cycle 10; the stream starts 1 cycle after the last bit and the data matches.
- Assert dn_stall for 2 cycles after idx 1. Expect x_valid low for those 2 cycles, idx 2 resumes afterwards, no value skipped or repeated, and frame_done still pulses.
- Drive 3 complete captures back-to-back during frame 1. Expect frame 2 pending and streamed right after DONE, overflow=1, frame 3 dropped, and overflow held until rst.
- Assert rst=0 for one cycle at idx 2. Expect x_valid=0 and busy=0 next cycle, no frame_done, and a fresh capture afterwards starting at idx 0.
- With LAYER_SEQ_ARGMAX_EN, send data {0xFFF0,0x0005,0x0005,0x0002}. Expect max_idx=1 and max_valid coincident with frame_done.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: state encoding and sizing helpers shared by the layer sequencer.
package layer_seq_pkg;

  localparam int NN_DEFAULT = 30;
  localparam int FRAME_LAST = NN_DEFAULT - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  // Bits needed to index n values; never narrower than one bit.
  function automatic int clog2_nn(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/layer_capture_buf.sv
// layer_capture_buf: per-neuron valid-flag accumulation plus the active (streaming)
// and pending frame buffers of layer_seq_ctrl; also owns the sticky overflow flag.
module layer_capture_buf
  import layer_seq_pkg::*;
#(
  parameter int NN        = FRAME_LAST + 1,
  parameter int dataWidth = 16,
  parameter int CNT_W     = clog2_nn(NN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           up_valid,
  input  logic [NN*dataWidth-1:0] up_data,
  input  logic                    load,
  input  logic [CNT_W-1:0]        rd_idx,
  output logic [dataWidth-1:0]    rd_data,
  output logic                    frame_avail,
  output logic                    overflow
);

  logic [NN-1:0]           flags;
  logic [NN*dataWidth-1:0] active_buf;
  logic [NN*dataWidth-1:0] pending_buf;
  logic                    pending_valid;
  logic                    cap_done;

  assign cap_done    = &(flags | up_valid);
  assign frame_avail = cap_done | pending_valid;
  assign rd_data     = active_buf[rd_idx*dataWidth +: dataWidth];

  // Every flagged neuron keeps following up_data until completion, so at the
  // completing edge the whole frame equals the current up_data bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags         <= '0;
      active_buf    <= '0;
      pending_buf   <= '0;
      pending_valid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      flags <= cap_done ? '0 : (flags | up_valid);
      if (load)
        active_buf <= pending_valid ? pending_buf : up_data;
      if (cap_done && pending_valid)
        overflow <= 1'b1;
      if (load && pending_valid) begin
        pending_valid <= 1'b0;
      end else if (cap_done && !load && !pending_valid) begin
        pending_buf   <= up_data;
        pending_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: captures a layer's parallel outputs and streams them serially to
// the next layer. Define LAYER_SEQ_ARGMAX_EN to add the max_idx/max_valid argmax outputs.
module layer_seq_ctrl
  import layer_seq_pkg::*;
#(
  parameter int NN        = FRAME_LAST + 1,
  parameter int dataWidth = 16,
  parameter int IDX_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           up_valid,
  input  logic [NN*dataWidth-1:0] up_data,
  input  logic                    dn_stall,
  output logic                    x_valid,
  output logic [dataWidth-1:0]    x_out,
  output logic [IDX_W-1:0]        x_idx,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overflow
`ifdef LAYER_SEQ_ARGMAX_EN
  ,
  output logic [IDX_W-1:0]        max_idx,
  output logic                    max_valid
`endif
);

  localparam int CNT_W = clog2_nn(NN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NN - 1);

  seq_state_t           state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [dataWidth-1:0] rd_data;
  logic                 frame_avail;
  logic                 load;
  logic                 issue;
  logic                 closing;

  layer_capture_buf #(
    .NN        (NN),
    .dataWidth (dataWidth),
    .CNT_W     (CNT_W)
  ) u_capture (
    .clk         (clk),
    .rst         (rst),
    .up_valid    (up_valid),
    .up_data     (up_data),
    .load        (load),
    .rd_idx      (cnt),
    .rd_data     (rd_data),
    .frame_avail (frame_avail),
    .overflow    (overflow)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (frame_avail) state_nx = SHIFT;
      SHIFT:   if (!dn_stall && cnt == LAST_IDX) state_nx = DONE;
      DONE:    state_nx = frame_avail ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // DONE may chain straight into the next frame when one is already waiting.
  always_comb begin
    load    = 1'b0;
    issue   = 1'b0;
    closing = 1'b0;
    unique case (state)
      IDLE:  load = frame_avail;
      SHIFT: issue = !dn_stall;
      DONE: begin
        closing = 1'b1;
        load    = frame_avail;
      end
      default: ;
    endcase
  end

  assign busy = (state == SHIFT) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      x_valid    <= 1'b0;
      x_out      <= '0;
      x_idx      <= '0;
      frame_done <= 1'b0;
    end else begin
      x_valid    <= issue;
      frame_done <= closing;
      if (load) begin
        cnt <= '0;
      end else if (issue) begin
        cnt   <= cnt + 1'b1;
        x_out <= rd_data;
        x_idx <= IDX_W'(cnt);
      end
    end
  end

`ifdef LAYER_SEQ_ARGMAX_EN
  logic signed [dataWidth-1:0] run_max;
  logic [CNT_W-1:0]            run_idx;

  // Strict greater-than keeps the lowest index on ties; index 0 seeds each frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_max   <= '0;
      run_idx   <= '0;
      max_idx   <= '0;
      max_valid <= 1'b0;
    end else begin
      max_valid <= closing;
      if (closing)
        max_idx <= IDX_W'(run_idx);
      if (issue && (cnt == '0 || $signed(rd_data) > run_max)) begin
        run_max <= rd_data;
        run_idx <= cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl: scoreboard bench for layer_seq_ctrl at NN=4, directed cases then
// random traffic. With LAYER_SEQ_ARGMAX_EN defined the argmax outputs are checked too.
module tb_layer_seq_ctrl;

  localparam int NN = 4;
  localparam int DW = 16;
  localparam int IW = 8;

  typedef logic [NN*DW-1:0] frame_t;
  typedef struct { int stamp; logic [DW-1:0] data; int idx; } item_t;
  typedef struct { int stamp; int amax; } done_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NN-1:0] up_valid;
  frame_t        up_data;
  logic          dn_stall;
  logic          x_valid;
  logic [DW-1:0] x_out;
  logic [IW-1:0] x_idx;
  logic          frame_done;
  logic          busy;
  logic          overflow;
`ifdef LAYER_SEQ_ARGMAX_EN
  logic [IW-1:0] max_idx;
  logic          max_valid;
`endif

  always #5 clk = ~clk;

  layer_seq_ctrl #(.NN(NN), .dataWidth(DW), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .dn_stall   (dn_stall),
    .x_valid    (x_valid),
    .x_out      (x_out),
    .x_idx      (x_idx),
    .frame_done (frame_done),
    .busy       (busy),
    .overflow   (overflow)
`ifdef LAYER_SEQ_ARGMAX_EN
    ,
    .max_idx    (max_idx),
    .max_valid  (max_valid)
`endif
  );

  item_t  exp_q[$];
  done_t  done_q[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;

  // Reference model: accepted frames in arrival order (head streams, one may wait).
  frame_t        inflight[$];
  int            issued = 0;
  logic [NN-1:0] m_flags = '0;
  logic          exp_ovf = 1'b0;
  logic          exp_busy = 1'b0;
  frame_t        cur;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic frame_t mkFrame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic [DW-1:0] c, input logic [DW-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic int argmaxOf(input frame_t f);
    int best;
    best = 0;
    for (int k = 1; k < NN; k++)
      if ($signed(f[k*DW +: DW]) > $signed(f[best*DW +: DW])) best = k;
    return best;
  endfunction

  task automatic acceptFrame(input frame_t d, input int max_held);
    if (inflight.size() < max_held) inflight.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic modelEdge(input logic r, input logic [NN-1:0] v, input frame_t d, input logic s);
    logic   cap;
    frame_t head;
    item_t  it;
    done_t  dn;
    if (!r) begin
      inflight.delete();
      issued   = 0;
      m_flags  = '0;
      exp_ovf  = 1'b0;
      exp_busy = 1'b0;
      return;
    end
    cap     = &(m_flags | v);
    m_flags = cap ? '0 : (m_flags | v);
    if (inflight.size() == 0) begin
      if (cap) begin
        inflight.push_back(d);
        issued = 0;
      end
    end else if (issued < NN) begin
      if (!s) begin
        head     = inflight[0];
        it.stamp = cyc;
        it.data  = head[issued*DW +: DW];
        it.idx   = issued;
        exp_q.push_back(it);
        issued++;
      end
      if (cap) acceptFrame(d, 2);
    end else begin
      dn.stamp = cyc;
      dn.amax  = argmaxOf(inflight[0]);
      done_q.push_back(dn);
      void'(inflight.pop_front());
      issued = 0;
      if (cap) acceptFrame(d, 1);
    end
    exp_busy = (inflight.size() != 0);
  endtask

  task automatic applyStimulus(input logic r, input logic [NN-1:0] v, input frame_t d, input logic s);
    rst      = r;
    up_valid = v;
    up_data  = d;
    dn_stall = s;
    @(posedge clk);
    cyc++;
    modelEdge(r, v, d, s);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, '0, cur, 1'b0);
  endtask

  task automatic runUntilIssued(input int n);
    int guard;
    guard = 0;
    while (!(inflight.size() > 0 && issued == n) && guard < 20) begin
      applyStimulus(1'b1, '0, cur, 1'b0);
      guard++;
    end
    total++;
    if (guard >= 20) begin
      bad++;
      $display("[TB] FAIL wait_idx%0d: got timeout want index reached (cycle %0d)", n, cyc);
    end
  endtask

  // Monitor: every cycle, compare DUT outputs against what the model scheduled.
  always @(negedge clk) begin : monitor
    item_t it;
    done_t dn;
    logic  want_v;
    logic  want_d;
    if (cyc > 0) begin
      want_v = (exp_q.size() > 0) && (exp_q[0].stamp == cyc);
      checkOutput("x_valid", {31'd0, x_valid}, {31'd0, want_v});
      if (want_v) begin
        it = exp_q.pop_front();
        if (x_valid) begin
          checkOutput("x_out", {16'd0, x_out}, {16'd0, it.data});
          checkOutput("x_idx", {24'd0, x_idx}, it.idx);
        end
      end
      want_d = (done_q.size() > 0) && (done_q[0].stamp == cyc);
      checkOutput("frame_done", {31'd0, frame_done}, {31'd0, want_d});
`ifdef LAYER_SEQ_ARGMAX_EN
      checkOutput("max_valid", {31'd0, max_valid}, {31'd0, want_d});
`endif
      if (want_d) begin
        dn = done_q.pop_front();
`ifdef LAYER_SEQ_ARGMAX_EN
        checkOutput("max_idx", {24'd0, max_idx}, dn.amax);
`endif
      end
      checkOutput("busy", {31'd0, busy}, {31'd0, exp_busy});
      checkOutput("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    end
  end

  initial begin
    logic [NN-1:0] v;
    cur = '0;
    applyStimulus(1'b0, '0, cur, 1'b0);
    applyStimulus(1'b0, '0, cur, 1'b0);
    checkOutput("rst_x_valid", {31'd0, x_valid}, 32'd0);
    checkOutput("rst_x_out", {16'd0, x_out}, 32'd0);
    checkOutput("rst_x_idx", {24'd0, x_idx}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);

    $display("[TB] all-valid frame");
    cur = mkFrame(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    applyStimulus(1'b1, 4'hF, cur, 1'b0);
    idle(8);

    $display("[TB] staggered valids");
    cur = mkFrame(16'h0111, 16'h0222, 16'h0333, 16'h0444);
    for (int c = 0; c < 10; c++) begin
      v = '0;
      if (c == 0) v = 4'b0001;
      if (c == 3) v = 4'b0010;
      if (c == 5) v = 4'b0100;
      if (c == 9) v = 4'b1000;
      applyStimulus(1'b1, v, cur, 1'b0);
    end
    idle(8);

    $display("[TB] downstream stall after idx 1");
    cur = mkFrame(16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00);
    applyStimulus(1'b1, 4'hF, cur, 1'b0);
    runUntilIssued(2);
    applyStimulus(1'b1, '0, cur, 1'b1);
    applyStimulus(1'b1, '0, cur, 1'b1);
    idle(8);

    $display("[TB] back-to-back captures");
    applyStimulus(1'b1, 4'hF, mkFrame(16'h1001, 16'h1002, 16'h1003, 16'h1004), 1'b0);
    applyStimulus(1'b1, 4'hF, mkFrame(16'h2001, 16'h2002, 16'h2003, 16'h2004), 1'b0);
    applyStimulus(1'b1, 4'hF, mkFrame(16'h3001, 16'h3002, 16'h3003, 16'h3004), 1'b0);
    applyStimulus(1'b1, 4'hF, mkFrame(16'h4001, 16'h4002, 16'h4003, 16'h4004), 1'b0);
    idle(20);
    checkOutput("overflow_sticky", {31'd0, overflow}, 32'd1);

    $display("[TB] reset mid-frame");
    cur = mkFrame(16'h0055, 16'h0066, 16'h0077, 16'h0088);
    applyStimulus(1'b1, 4'hF, cur, 1'b0);
    runUntilIssued(2);
    applyStimulus(1'b0, '0, cur, 1'b0);
    checkOutput("midrst_x_valid", {31'd0, x_valid}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_overflow", {31'd0, overflow}, 32'd0);
    idle(3);
    cur = mkFrame(16'h0123, 16'h0456, 16'h0789, 16'h0ABC);
    applyStimulus(1'b1, 4'hF, cur, 1'b0);
    idle(8);

    $display("[TB] argmax frame");
    cur = mkFrame(16'hFFF0, 16'h0005, 16'h0005, 16'h0002);
    applyStimulus(1'b1, 4'hF, cur, 1'b0);
    idle(8);

    $display("[TB] random traffic");
    applyStimulus(1'b0, '0, cur, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (m_flags == '0) cur = {$urandom, $urandom};
      v = NN'($urandom_range(0, 15) & $urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 99) != 0), v, cur, ($urandom_range(0, 3) == 0));
    end
    idle(20);

    checkOutput("exp_q_drained", exp_q.size(), 32'd0);
    checkOutput("done_q_drained", done_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
